// File: rtl/fir_coef_sequencer_if.sv
// fir_coef_sequencer_if
// Groups the host shadow-bank port, the filter coefficient/mode port and the
// masked valid into one bundle. The master side is the host plus the filter's
// data_out_valid; the slave side is the sequencer.
interface fir_coef_sequencer_if #(
  parameter int COEF_WIDTH = 16
);
  // Host shadow-bank access and commit request
  logic                         wr_en;
  logic [3:0]                   wr_addr;
  logic [COEF_WIDTH-1:0]        wr_data;
  logic [1:0]                   wr_mode;
  logic                         commit;
  // Host status
  logic                         busy;
  logic                         commit_done;
  logic                         reject;
  // Filter reconfiguration port
  logic                         fir_coef_load;
  logic [3:0]                   fir_coef_addr;
  logic [COEF_WIDTH-1:0]        fir_coef_data;
  logic [1:0]                   fir_filter_mode;
  // Filter output valid in, masked valid out to the DPLL
  logic                         fir_out_valid;
  logic                         out_valid;
  // Gain check results (tied to zero unless the gain check is built in)
  logic signed [COEF_WIDTH+3:0] coef_sum;
  logic                         unity_gain;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mode, commit, fir_out_valid,
    input  busy, commit_done, reject, fir_coef_load, fir_coef_addr,
           fir_coef_data, fir_filter_mode, out_valid, coef_sum, unity_gain
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mode, commit, fir_out_valid,
    output busy, commit_done, reject, fir_coef_load, fir_coef_addr,
           fir_coef_data, fir_filter_mode, out_valid, coef_sum, unity_gain
  );
endinterface

// File: rtl/fir_coef_sequencer.sv
// fir_coef_sequencer
// Runtime reconfiguration controller for one fir_flux_filter. The host fills a
// shadow bank and commits; the sequencer streams the bank into the filter
// (adaptive mode only), switches filter_mode, then hides the filter's valid
// until SETTLE_SAMPLES outputs computed under the new setup have gone by.
// Optional build macro: FIR_SEQ_GAIN_CHECK_EN adds a running sum of the loaded
// coefficients and a unity-gain flag; without it those outputs are tied to 0.
module fir_coef_sequencer #(
  parameter int NUM_TAPS       = 16,
  parameter int COEF_WIDTH     = 16,
  parameter int SETTLE_SAMPLES = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_coef_sequencer_if.slave  bus
);

  localparam int          ADDR_W        = 4;
  localparam int          CNT_W         = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam logic [31:0] NUM_TAPS_U    = NUM_TAPS;
  localparam logic [31:0] SETTLE_U      = SETTLE_SAMPLES;
  localparam logic [1:0]  MODE_BYPASS   = 2'b00;
  localparam logic [1:0]  MODE_ADAPTIVE = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SWITCH,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      tap_q, tap_d;
  logic [1:0]             tgt_mode_q, tgt_mode_d;
  logic [1:0]             mode_q, mode_d;
  logic [CNT_W-1:0]       settle_cnt_q, settle_cnt_d;
  logic                   load_q, load_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [COEF_WIDTH-1:0]  data_q, data_d;
  logic                   reject_q, reject_d;

  logic                   idle;
  logic                   addr_in_range;
  logic                   wr_ok;
  logic                   last_tap;
  logic                   settle_hit;
  logic [ADDR_W-1:0]      rd_addr;
  logic [COEF_WIDTH-1:0]  rd_data;
  logic [COEF_WIDTH-1:0]  shadow_rd [NUM_TAPS];

  assign idle          = (state_q == ST_IDLE);
  assign addr_in_range = (32'(bus.wr_addr) < NUM_TAPS_U);
  // Host writes only land while idle; everything else is dropped and flagged.
  assign wr_ok         = idle & bus.wr_en & addr_in_range;
  assign last_tap      = (32'(tap_q) == NUM_TAPS_U - 32'd1);
  assign settle_hit    = (32'(settle_cnt_q) == SETTLE_U - 32'd1);

  // Shadow bank: one register per tap so the whole bank clears on reset.
  generate
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_shadow
      logic [COEF_WIDTH-1:0] entry_q;

      // Capture an accepted host write aimed at this tap.
      always_ff @(posedge clk) begin
        if (reset) begin
          entry_q <= '0;
        end else if (wr_ok && (bus.wr_addr == ADDR_W'(gi))) begin
          entry_q <= bus.wr_data;
        end
      end

      assign shadow_rd[gi] = entry_q;
    end
  endgenerate

  // The tap read here is the one presented on the next cycle: tap 0 when the
  // commit is taken, tap k+1 while tap k is on the bus. A write landing on the
  // commit cycle is forwarded so it reaches the filter in this very load.
  assign rd_addr = idle ? '0 : ADDR_W'(tap_q + 1'b1);
  assign rd_data = (wr_ok && (bus.wr_addr == rd_addr)) ? bus.wr_data : shadow_rd[rd_addr];

  // Next-state and registered-output decode for the reconfiguration sequence.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    tgt_mode_d   = tgt_mode_q;
    mode_d       = mode_q;
    settle_cnt_d = settle_cnt_q;
    load_d       = 1'b0;
    addr_d       = '0;
    data_d       = '0;
    reject_d     = (bus.wr_en & ~wr_ok) | (bus.commit & ~idle);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.commit) begin
          tgt_mode_d = bus.wr_mode;
          if (bus.wr_mode == MODE_ADAPTIVE) begin
            state_d = ST_LOAD;
            tap_d   = '0;
            load_d  = 1'b1;
            addr_d  = '0;
            data_d  = rd_data;
          end else begin
            state_d = ST_SWITCH;
          end
        end
      end

      ST_LOAD: begin
        if (last_tap) begin
          state_d = ST_SWITCH;
          tap_d   = '0;
        end else begin
          tap_d  = ADDR_W'(tap_q + 1'b1);
          load_d = 1'b1;
          addr_d = ADDR_W'(tap_q + 1'b1);
          data_d = rd_data;
        end
      end

      ST_SWITCH: begin
        mode_d       = tgt_mode_q;
        settle_cnt_d = '0;
        state_d      = (SETTLE_SAMPLES == 0) ? ST_DONE : ST_SETTLE;
      end

      ST_SETTLE: begin
        if (bus.fir_out_valid) begin
          if (settle_hit) begin
            state_d = ST_DONE;
          end
          // Saturate rather than wrap so a stray extra pulse cannot restart the count.
          if (settle_cnt_q != CNT_MAX) begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tap_q        <= '0;
      tgt_mode_q   <= MODE_BYPASS;
      mode_q       <= MODE_BYPASS;
      settle_cnt_q <= '0;
      load_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      tgt_mode_q   <= tgt_mode_d;
      mode_q       <= mode_d;
      settle_cnt_q <= settle_cnt_d;
      load_q       <= load_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      reject_q     <= reject_d;
    end
  end

  assign bus.busy            = ~idle;
  assign bus.commit_done     = (state_q == ST_DONE);
  assign bus.reject          = reject_q;
  assign bus.fir_coef_load   = load_q;
  assign bus.fir_coef_addr   = addr_q;
  assign bus.fir_coef_data   = data_q;
  assign bus.fir_filter_mode = mode_q;
  // The filter's adaptive bank is live while being rewritten, so the whole
  // busy window (load included) is hidden from the DPLL.
  assign bus.out_valid       = bus.fir_out_valid & ~bus.busy;

`ifdef FIR_SEQ_GAIN_CHECK_EN
  localparam int SUM_W = COEF_WIDTH + 4;
  localparam logic signed [SUM_W-1:0] UNITY = SUM_W'(32768);

  logic signed [SUM_W-1:0] coef_sum_q;
  logic                    unity_q;
  logic                    adaptive_commit;

  assign adaptive_commit = idle & bus.commit & (bus.wr_mode == MODE_ADAPTIVE);

  // Sum the coefficients exactly as they are driven to the filter.
  always_ff @(posedge clk) begin
    if (reset) begin
      coef_sum_q <= '0;
    end else if (adaptive_commit) begin
      coef_sum_q <= '0;
    end else if (state_q == ST_LOAD) begin
      coef_sum_q <= coef_sum_q + $signed({{4{data_q[COEF_WIDTH-1]}}, data_q});
    end
  end

  // Judge the gain once the load is complete; non-adaptive commits keep the old verdict.
  always_ff @(posedge clk) begin
    if (reset) begin
      unity_q <= 1'b0;
    end else if ((state_q == ST_SWITCH) && (tgt_mode_q == MODE_ADAPTIVE)) begin
      unity_q <= (coef_sum_q == UNITY);
    end
  end

  assign bus.coef_sum   = coef_sum_q;
  assign bus.unity_gain = unity_q;
`else
  assign bus.coef_sum   = '0;
  assign bus.unity_gain = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// tb_fir_coef_sequencer
// Table-driven opening vectors, hand-written corner sequences, then random
// traffic, all compared against a timeline model of a commit: loads on cycles
// 1..NUM_TAPS after acceptance, mode switch, then SETTLE_SAMPLES counted pulses.
module tb_fir_coef_sequencer;

  localparam int NT = 16;
  localparam int CW = 16;
  localparam int SS = 20;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fir_coef_sequencer_if #(.COEF_WIDTH(CW)) bus ();

  fir_coef_sequencer #(
    .NUM_TAPS(NT),
    .COEF_WIDTH(CW),
    .SETTLE_SAMPLES(SS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit          rs;
    bit          we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  wm;
    bit          cm;
    bit          fv;
    bit          e_busy;
    bit          e_done;
    bit          e_rej;
    bit          e_load;
    logic [1:0]  e_mode;
    bit          e_ov;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state
  logic [CW-1:0] m_shadow [NT];
  logic [CW-1:0] m_snap   [NT];
  logic [1:0]    m_mode;
  logic [1:0]    m_tgt;
  bit            m_active;
  int            m_t;
  int            m_pulses;
  int            m_done_t;
  bit            m_rej;
  logic [19:0]   m_sum;
  bit            m_unity;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      m_shadow[k] = '0;
      m_snap[k]   = '0;
    end
    m_mode   = 2'b00;
    m_tgt    = 2'b00;
    m_active = 1'b0;
    m_t      = 0;
    m_pulses = 0;
    m_done_t = -1;
    m_rej    = 1'b0;
    m_sum    = '0;
    m_unity  = 1'b0;
  endtask

  function automatic int switch_time(input logic [1:0] mode);
    return (mode == 2'b11) ? NT + 1 : 1;
  endfunction

  // Compare every DUT output for the current cycle with the model.
  task automatic model_check(input bit fv);
    bit ld;
    ld = m_active && (m_tgt == 2'b11) && (m_t >= 1) && (m_t <= NT);
    chk("busy", bus.busy, m_active);
    chk("commit_done", bus.commit_done, m_active && (m_t == m_done_t));
    chk("reject", bus.reject, m_rej);
    chk("coef_load", bus.fir_coef_load, ld);
    if (ld) begin
      chk("coef_addr", bus.fir_coef_addr, m_t - 1);
      chk("coef_data", bus.fir_coef_data, m_snap[m_t-1]);
    end
    chk("filter_mode", bus.fir_filter_mode, m_mode);
    chk("out_valid", bus.out_valid, fv && !m_active);
    if (!m_active) begin
`ifdef FIR_SEQ_GAIN_CHECK_EN
      chk("coef_sum", bus.coef_sum, m_sum);
      chk("unity_gain", bus.unity_gain, m_unity);
`else
      chk("coef_sum", bus.coef_sum, 20'd0);
      chk("unity_gain", bus.unity_gain, 1'b0);
`endif
    end
  endtask

  // Advance the model across one clock edge given this cycle's inputs.
  task automatic model_update(input bit rs, input bit we, input logic [3:0] wa,
                              input logic [15:0] wd, input logic [1:0] wm,
                              input bit cm, input bit fv);
    int s_t;
    int sum;
    if (rs) begin
      model_reset();
      return;
    end
    m_rej = (we && (m_active || (int'(wa) >= NT))) || (cm && m_active);
    if (!m_active) begin
      if (we && (int'(wa) < NT)) m_shadow[wa] = wd;
      if (cm) begin
        $display("txn: commit mode=%0d accepted at cycle %0d", wm, cyc);
        m_active = 1'b1;
        m_t      = 1;
        m_tgt    = wm;
        m_pulses = 0;
        m_done_t = (SS == 0) ? switch_time(wm) + 1 : -1;
        for (int k = 0; k < NT; k++) m_snap[k] = m_shadow[k];
        if (wm == 2'b11) begin
          sum = 0;
          for (int k = 0; k < NT; k++) sum += int'($signed(m_snap[k]));
          m_sum   = 20'(sum);
          m_unity = (sum == 32768);
        end
      end
    end else begin
      s_t = switch_time(m_tgt);
      if (m_t == s_t) m_mode = m_tgt;
      if (m_t == m_done_t) begin
        m_active = 1'b0;
      end else if ((m_t > s_t) && (m_done_t < 0) && fv) begin
        m_pulses++;
        if (m_pulses == SS) m_done_t = m_t + 1;
      end
      m_t++;
    end
  endtask

  task automatic drive(input bit rs, input bit we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic [1:0] wm,
                       input bit cm, input bit fv);
    reset             = rs;
    bus.wr_en         = we;
    bus.wr_addr       = wa;
    bus.wr_data       = wd;
    bus.wr_mode       = wm;
    bus.commit        = cm;
    bus.fir_out_valid = fv;
  endtask

  // One model-checked clock cycle; entered and left at posedge + 1.
  task automatic cycle(input bit rs, input bit we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic [1:0] wm,
                       input bit cm, input bit fv);
    drive(rs, we, wa, wd, wm, cm, fv);
    #1;
    model_check(fv);
    model_update(rs, we, wa, wd, wm, cm, fv);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycle(input bit fv);
    cycle(1'b0, 1'b0, 4'd0, 16'd0, 2'b00, 1'b0, fv);
  endtask

  // One table-checked clock cycle; the model is kept in step silently.
  task automatic vec_cycle(input vec_t v);
    drive(v.rs, v.we, v.wa, v.wd, v.wm, v.cm, v.fv);
    #1;
    chk("tbl_busy", bus.busy, v.e_busy);
    chk("tbl_commit_done", bus.commit_done, v.e_done);
    chk("tbl_reject", bus.reject, v.e_rej);
    chk("tbl_coef_load", bus.fir_coef_load, v.e_load);
    chk("tbl_filter_mode", bus.fir_filter_mode, v.e_mode);
    chk("tbl_out_valid", bus.out_valid, v.e_ov);
    model_update(v.rs, v.we, v.wa, v.wd, v.wm, v.cm, v.fv);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Let the current sequence run to completion, with a bounded cycle budget.
  task automatic run_until_idle(input bit rand_fv, input int budget);
    int n;
    n = 0;
    while (m_active && (n < budget)) begin
      idle_cycle(rand_fv ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    chk("settle_timeout_active", m_active, 1'b0);
    idle_cycle(1'b1);
  endtask

  vec_t vecs [10];

  initial begin
    // rs we wa wd wm cm fv | busy done rej load mode ov
    vecs[0] = '{1'b0, 1'b0, 4'd0,  16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 4'd0,  16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 4'd15, 16'h1234, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 4'd0,  16'h0000, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 4'd0,  16'h0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 4'd0,  16'h0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 4'd0,  16'h0000, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 4'd0,  16'h0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 4'd3,  16'h0007, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 4'd0,  16'h0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0};

    drive(1'b1, 1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, lowpass commit and the first rejects
    for (int i = 0; i < 10; i++) vec_cycle(vecs[i]);
    // Finish the lowpass settle window with valid held high
    run_until_idle(1'b0, 100);

    // Adaptive load with rejects during LOAD and SETTLE; shadow[3] must stay 0
    cycle(1'b0, 1'b0, 4'd0, 16'd0, 2'b11, 1'b1, 1'b0);
    repeat (3) idle_cycle(1'b1);
    cycle(1'b0, 1'b1, 4'd3, 16'h7777, 2'b00, 1'b0, 1'b0);
    while (m_active && (m_t <= NT + 3)) idle_cycle(1'b0);
    cycle(1'b0, 1'b0, 4'd0, 16'd0, 2'b01, 1'b1, 1'b1);
    run_until_idle(1'b1, 300);

    // Unity-gain bank: every tap 2048
    for (int k = 0; k < NT; k++) cycle(1'b0, 1'b1, 4'(k), 16'd2048, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 16'd0, 2'b11, 1'b1, 1'b1);
    run_until_idle(1'b1, 300);

    // Reset while tap 7 is on the coefficient bus
    cycle(1'b0, 1'b0, 4'd0, 16'd0, 2'b11, 1'b1, 1'b0);
    while (m_active && (m_t < 8)) idle_cycle(1'b1);
    chk("mid_load_addr", bus.fir_coef_addr, 4'd7);
    cycle(1'b1, 1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 1'b1);
    chk("mid_reset_mode", bus.fir_filter_mode, 2'b00);
    chk("mid_reset_load", bus.fir_coef_load, 1'b0);
    idle_cycle(1'b1);

    // Write and commit on the same cycle: first load carries the new word
    cycle(1'b0, 1'b1, 4'd0, 16'hFE00, 2'b11, 1'b1, 1'b0);
    chk("same_cycle_data", bus.fir_coef_data, 16'hFE00);
    run_until_idle(1'b1, 300);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 399) == 0),
            1'($urandom_range(0, 9) < 3),
            4'($urandom_range(0, 15)),
            16'($urandom),
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)));
    end
    run_until_idle(1'b1, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fir_coef_sequencer.md
Name: fir_coef_sequencer

Overview:
Controller that reconfigures one fir_flux_filter instance at runtime without corrupting the flux stream fed to the DPLL. The host writes a target mode and up to NUM_TAPS adaptive coefficients into a shadow bank, then issues a commit. The sequencer streams the shadow bank into the filter's coefficient port and switches filter_mode. It then masks the filter's output-valid until the delay line and adder pipeline have refilled with samples produced under the new coefficients.

Parameters:
NUM_TAPS, 16, filter taps; also the shadow bank depth and the LOAD length.
COEF_WIDTH, 16, signed coefficient width.
SETTLE_SAMPLES, 20, number of filter output-valid pulses discarded after a mode/coefficient change (NUM_TAPS + adder pipeline). A value of 0 skips SETTLE.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  shadow coefficient write strobe
wr_addr  in  4  shadow address
wr_data  in  COEF_WIDTH  shadow coefficient value
wr_mode  in  2  target filter_mode, latched at commit
commit  in  1  single-cycle request to apply the shadow configuration
busy  out  1  high from commit acceptance until return to IDLE
commit_done  out  1  single-cycle pulse on return to IDLE
reject  out  1  single-cycle pulse when a wr_en or commit is dropped
fir_coef_load  out  1  to filter coef_load
fir_coef_addr  out  4  to filter coef_addr
fir_coef_data  out  COEF_WIDTH  to filter coef_data
fir_filter_mode  out  2  to filter filter_mode
fir_out_valid  in  1  filter data_out_valid
out_valid  out  1  masked valid forwarded to the DPLL
coef_sum  out  COEF_WIDTH+4  signed sum of the last loaded coefficients (optional feature)
unity_gain  out  1  coef_sum == 32768 (optional feature)

Behaviour:
- Reset values:
  - busy, commit_done, reject, fir_coef_load: 0
  - fir_coef_addr, fir_coef_data: 0
  - fir_filter_mode: 2'b00 (bypass)
  - shadow bank: all 0
  - state: IDLE
  - coef_sum, unity_gain: 0
- Reset asserted mid-operation aborts immediately to the reset values. No partial-load recovery is attempted.
- Shadow writes:
  - Accepted only in IDLE when wr_addr < NUM_TAPS.
  - A wr_en while busy, or with wr_addr >= NUM_TAPS, is dropped and pulses reject the next cycle.
- Commit:
  - Accepted only in IDLE. A commit while busy is dropped and pulses reject.
  - Commit and wr_en in the same IDLE cycle: the write lands first and is included in the load.
- States:
  - IDLE: on commit, latch wr_mode into tgt_mode and set busy the next cycle. Go to LOAD if tgt_mode == 2'b11, otherwise to SWITCH.
  - LOAD: exactly NUM_TAPS consecutive cycles. Each cycle drives fir_coef_load = 1, fir_coef_addr = k, fir_coef_data = shadow[k], for k = 0..NUM_TAPS-1 in order. Then go to SWITCH.
  - SWITCH: one cycle. fir_filter_mode <= tgt_mode, visible the following cycle. Go to SETTLE, or to DONE if SETTLE_SAMPLES == 0.
  - SETTLE: count fir_out_valid pulses. On the SETTLE_SAMPLES-th pulse, go to DONE.
  - DONE: one cycle. Pulse commit_done, drop busy, return to IDLE.
- Timing for commit accepted at cycle T with tgt_mode 11:
  - fir_coef_load is high on T+1..T+NUM_TAPS.
  - SWITCH is at T+NUM_TAPS+1.
  - fir_filter_mode is new from T+NUM_TAPS+2.
- Masking:
  - out_valid = fir_out_valid & ~busy, combinational.
  - Masking therefore covers LOAD as well, because the filter's adaptive bank is live while it is rewritten.
- Recommitting the currently active mode still runs the full sequence, including settle.
- The settle counter is wide enough for SETTLE_SAMPLES and saturates; it does not wrap.

Optional Feature:
FIR_SEQ_GAIN_CHECK_EN
- Defined:
  - coef_sum clears in IDLE on commit acceptance and accumulates fir_coef_data (sign-extended) on every LOAD cycle.
  - unity_gain is registered in SWITCH as (coef_sum == 32768).
  - For non-adaptive commits, both outputs hold their previous values.
- Undefined: coef_sum and unity_gain are tied to 0 and no accumulator is synthesised.

Test Plan:
- Reset check: after reset, fir_filter_mode = 00, busy = 0, out_valid follows nothing. With fir_out_valid = 1, out_valid = 1.
- Lowpass commit: commit with wr_mode = 01 -> no fir_coef_load pulses; fir_filter_mode = 01 two cycles later; out_valid masked for exactly 20 fir_out_valid pulses; then a commit_done pulse.
- Adaptive load: write shadow[k] = 2048 for all 16 taps, then commit with mode 11 -> 16 consecutive load cycles with addr 0..15 and data 2048; mode = 11 at T+18; with the macro, coef_sum = 32768 and unity_gain = 1.
- Rejects: wr_en during LOAD, commit during SETTLE, and wr_addr = 15 accepted -> reject pulses for the first two cases only; shadow unchanged; the sequence is unaffected.
- Reset mid-LOAD: assert reset at load k = 7 -> all outputs at reset values the next cycle; fir_filter_mode = 00.
- Same-cycle write and commit: wr_en (addr 0 = -512) with commit, mode 11 -> the first load cycle carries -512.
